// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential/branch/jump/return sources and optional return-address stack
//   Optional feature macro: PC_RAS_EN (defined builds the RAS and its flags; undefined ties them off).
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     enable                advance PC and RAS when high, hold when low
//     sel[1:0]              next source: 00 seq, 01 branch, 10 jump, 11 return
//     adr, offset           jump target, signed branch offset
//     call                  push pc+STEP onto the RAS
//     err_clr               clear sticky ras_ovf / ras_unf
//     pc                    current fetch address (registered)
//     misalign              one-cycle pulse: last loaded target had low bits set
//     ras_empty, ras_full   decoded from registered RAS count
//     ras_ovf, ras_unf      sticky overflow / underflow flags
module pc_unit #(
    parameter int               WIDTH      = 32,
    parameter int               STEP       = 4,
    parameter int               ALIGN_BITS = 2,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter int               RAS_DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] offset,
    input  logic             call,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pc,
    output logic             misalign,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic [WIDTH-1:0] r_pc;
    logic             r_misalign;
    logic [WIDTH-1:0] w_seq;
    logic [WIDTH-1:0] w_ret_adr;
    logic             w_ret_ok;
    logic [WIDTH-1:0] w_target;

    assign w_seq = r_pc + WIDTH'(STEP);

`ifdef PC_RAS_EN
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf;
    logic             r_unf;
    logic             w_ret;
    logic             w_pop;
    logic             w_push;
    logic             w_full;
    logic [PW-1:0]    w_wr_idx;

    assign w_ret     = enable && sel == 2'b11;
    assign w_pop     = w_ret && r_cnt != '0;
    assign w_push    = enable && call;
    assign w_full    = r_cnt == CW'(RAS_DEPTH);
    // Pop+push replaces the top in place; a plain push advances, which on a
    // full stack lands on the oldest slot because the pointer wraps.
    assign w_wr_idx  = w_pop ? r_top : r_top + PW'(1);
    assign w_ret_ok  = r_cnt != '0;
    assign w_ret_adr = r_stack[r_top];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_push) begin
                r_top <= w_wr_idx;
                r_cnt <= (w_pop || w_full) ? r_cnt : r_cnt + CW'(1);
            end else if (w_pop) begin
                r_top <= r_top - PW'(1);
                r_cnt <= r_cnt - CW'(1);
            end
            r_ovf <= (w_push && w_full && !w_pop) || (r_ovf && !err_clr);
            r_unf <= (w_ret && r_cnt == '0) || (r_unf && !err_clr);
        end
    end

    // Storage is deliberately not reset; a zero count hides stale entries.
    always_ff @(posedge clk) begin
        if (w_push) r_stack[w_wr_idx] <= w_seq;
    end

    assign ras_empty = r_cnt == '0;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;
`else
    logic w_unused;

    assign w_unused  = &{1'b0, call, err_clr};
    assign w_ret_ok  = 1'b0;
    assign w_ret_adr = w_seq;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
    assign ras_ovf   = 1'b0;
    assign ras_unf   = 1'b0;
`endif

    // Return with nothing to pop (or no RAS built) falls back to sequential.
    assign w_target = sel == 2'b01 ? r_pc + offset :
                      sel == 2'b10 ? adr :
                      (sel == 2'b11 && w_ret_ok) ? w_ret_adr : w_seq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_VEC & ~LOW_MASK;
            r_misalign <= 1'b0;
        end else begin
            if (enable) r_pc <= w_target & ~LOW_MASK;
            r_misalign <= enable && sel != 2'b00 && |(w_target & LOW_MASK);
        end
    end

    assign pc       = r_pc;
    assign misalign = r_misalign;
endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit: the next-generation replacement for the single-register PC. It holds the current fetch address and computes the next one every enabled cycle. Sources are sequential increment, PC-relative branch, absolute jump, or return from a hardware return-address stack (RAS). It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface

**Parameters**
- `WIDTH`, 32: address width in bits.
- `STEP`, 4: sequential increment in bytes.
- `ALIGN_BITS`, 2: low address bits forced to zero on every load.
- `RESET_VEC`, 0: PC value after reset.
- `RAS_DEPTH`, 8: return-address-stack entries (power of two, ≥2).

**Ports** (one clock `clk`; reset `rst_n` is asynchronous, active-low)
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `enable`, in, 1: advance when high; hold everything (PC and RAS) when low.
- `sel`, in, 2: next-PC source: 00 seq, 01 branch, 10 jump, 11 return.
- `adr`, in, WIDTH: absolute jump target.
- `offset`, in, WIDTH: signed two's-complement branch offset.
- `call`, in, 1: push return address (`pc + STEP`) this cycle.
- `err_clr`, in, 1: synchronous clear of the sticky error flags.
- `pc`, out, WIDTH: current PC (registered).
- `misalign`, out, 1: one-cycle pulse; the last loaded target had nonzero low bits.
- `ras_empty`, out, 1: RAS holds 0 entries.
- `ras_full`, out, 1: RAS holds `RAS_DEPTH` entries.
- `ras_ovf`, out, 1: sticky flag; a push occurred while full.
- `ras_unf`, out, 1: sticky flag; a return occurred while empty.

## Operation

- Next PC is computed as follows; all arithmetic is modulo 2^WIDTH, so wrap-around is silent.
  - seq: `pc + STEP`.
  - branch: `pc + offset`.
  - jump: `adr`.
  - return: RAS top. If the RAS is empty, use `pc + STEP` and set `ras_unf`.
- The low `ALIGN_BITS` of the next PC are cleared on load. `misalign` is registered high for one cycle if any cleared bit was 1 (branch, jump or return only; seq never flags).
- RAS is a circular stack with `RAS_DEPTH` entries, a top pointer and a count.
  - **Push** (`call` and `enable`) writes `pc + STEP`, pre-alignment-clear.
  - **Push when full** overwrites the oldest entry; count stays at `RAS_DEPTH`; `ras_ovf` is set.
  - **Pop** (`sel`=11 and `enable`) on a non-empty RAS decrements the count.
  - **Pop and push in the same cycle**: the top entry is replaced by the new return address; count is unchanged. The pop reads the old top first.
  - Pop+push on an empty RAS: `ras_unf` is set, then the push proceeds (count becomes 1).
- `enable` low: `pc`, RAS and count are frozen; `misalign` drops to 0. Sticky flags hold.
- `err_clr` clears `ras_ovf` and `ras_unf` regardless of `enable`. A same-cycle set wins over clear.

## Timing

- Single-cycle latency: inputs are sampled at rising edge N; the new `pc` is visible after edge N.
- No handshake; `enable` is the only qualifier. Inputs other than `enable`, `call`, `sel` and `err_clr` are don't-care when the source does not use them.
- Reset (asynchronous, any time, including mid-push or mid-return):
  - `pc`=RESET_VEC, with the low `ALIGN_BITS` cleared.
  - RAS count=0, so `ras_empty`=1 and `ras_full`=0.
  - `misalign`=0, `ras_ovf`=0, `ras_unf`=0.
  - RAS storage contents are not reset; they are unreadable while the count is 0.
- Release of `rst_n` is synchronised externally. The first advance is on the first enabled edge after release.
- `ras_empty` and `ras_full` are decoded from the registered count and are valid in the same cycle as `pc`.

## Configuration

- `PC_RAS_EN` defined: the RAS and its flags are built as described above.
- `PC_RAS_EN` undefined:
  - No RAS storage is built.
  - `sel`=11 behaves as seq; `call` is ignored.
  - `ras_empty` is tied to 1; `ras_full`, `ras_ovf` and `ras_unf` are tied to 0.
  - Port list is unchanged.

## Test plan

- **Reset, stall and sequential advance.** Assert `rst_n`=0 mid-run → `pc`=0 and `ras_empty`=1 immediately. Release, `enable`=0 for 3 cycles → `pc` stays 0. Then `enable`=1, `sel`=00 for 3 cycles → `pc` = 4, 8, 12.
- **Branch, jump and wrap-around.**
  - At `pc`=0x100, branch with `offset`=0xFFFFFFF0 → `pc`=0xF0.
  - Jump `adr`=0x2003 → `pc`=0x2000, `misalign`=1 for exactly one cycle.
  - At `pc`=0xFFFFFFFC, seq → `pc`=0.
- **Call and return.**
  - At `pc`=0x40: jump to 0x800 with `call`=1 → `pc`=0x800, RAS top=0x44.
  - At 0x800: jump to 0x900 with `call`=1 → `pc`=0x900, RAS holds 2.
  - Two returns → `pc`=0x804, then 0x44; `ras_empty`=1.
- **Overflow.** With `RAS_DEPTH`=8, make 9 calls (return addresses A1..A9) → `ras_ovf`=1 and `ras_full`=1. Eight returns yield A9 down to A2, then `ras_empty`=1. `err_clr` → `ras_ovf`=0.
- **Underflow and simultaneous pop+push.**
  - Return on empty at `pc`=0x10 → `pc`=0x14, `ras_unf`=1.
  - With RAS top=0x44 and count=1, at `pc`=0x200 drive `sel`=11 and `call`=1 together → `pc`=0x44, top=0x204, count=1.
- **Macro off.** Build without `PC_RAS_EN`: `call`=1 with `sel`=11 at `pc`=0x20 → `pc`=0x24. `ras_empty`=1 and all other RAS flags stay 0.
